// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// Frame controller state encoding and serial line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit shift register and bit counter for one UART frame.
// Exposes the current LSB and the bit that follows it after a shift.
module uart_tx_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             cur_bit,
    output logic             next_bit,
    output logic             ser_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    assign cur_bit  = sreg[0];
    assign next_bit = sreg[1];
    assign ser_done = (cnt == CW'(WIDTH - 1));

    // Load a word on acceptance, then shift right one bit per data cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= data_in;
        end else if (shift) begin
            sreg <= sreg >> 1;
            cnt  <= ser_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, data LSB first,
// optional parity and stop bit, with back-to-back frames.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_BIT,
    output logic             PAR_calc,
    output logic             TX_OUT,
    output logic             Busy
);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   par_en_q;
    logic   tx_next;
    logic   cur_bit;
    logic   next_bit;
    logic   ser_done;

    assign accept   = DATA_VALID && !RST &&
                      (state == IDLE || state == STOP);
    assign PAR_calc = accept;

    uart_tx_serializer #(
        .WIDTH (WIDTH)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (accept),
        .shift    (state == DATA),
        .data_in  (P_DATA),
        .cur_bit  (cur_bit),
        .next_bit (next_bit),
        .ser_done (ser_done)
    );

    // Next state and the line level that state will present.
    always_comb begin
        next_state = state;
        tx_next    = STOP_BIT;
        unique case (state)
            IDLE:    if (accept) next_state = START;
            START:   next_state = DATA;
            DATA:    if (ser_done) next_state = par_en_q ? PARITY : STOP;
            PARITY:  next_state = STOP;
            STOP:    next_state = accept ? START : IDLE;
            default: next_state = IDLE;
        endcase
        unique case (next_state)
            START:   tx_next = START_BIT;
            DATA:    tx_next = (state == DATA) ? next_bit : cur_bit;
            PARITY:  tx_next = PAR_BIT;
            default: tx_next = STOP_BIT;
        endcase
    end

    // State, line and busy flag update together on each baud edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            TX_OUT   <= STOP_BIT;
            Busy     <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_next;
            Busy   <= (next_state != IDLE);
            if (accept) par_en_q <= PAR_EN;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a parity_calc model
// and a frame-level reference built from the word under test.
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_BIT;
    logic       PAR_TYP;
    logic       PAR_calc;
    logic       TX_OUT;
    logic       Busy;

    int n_checks;
    int n_fail;
    bit exp_q[$];

    uart_tx_ctrl #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_BIT    (PAR_BIT),
        .PAR_calc   (PAR_calc),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stand-in for parity_calc: registers parity of the captured word.
    always @(posedge CLK) begin
        if (RST) PAR_BIT <= 1'b0;
        else if (PAR_calc) PAR_BIT <= PAR_TYP ? ~^P_DATA : ^P_DATA;
    end

    // Append the expected line sequence of one frame.
    function automatic void add_frame(input logic [7:0] d,
                                      input logic pe,
                                      input logic typ);
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
        if (pe) exp_q.push_back(typ ? ~^d : ^d);
        exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA = 8'hFF;
        PAR_EN = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx: got %b expected 1", TX_OUT);
        end
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", Busy);
        end
        n_checks++;
        if (PAR_calc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_par_calc: got %b expected 0", PAR_calc);
        end
        RST = 1'b0;
        DATA_VALID = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got tx=%b busy=%b expected tx=1 busy=0",
                     TX_OUT, Busy);
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input logic pe,
                              input logic typ, input string tag);
        exp_q.delete();
        add_frame(d, pe, typ);
        @(negedge CLK);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = typ;
        DATA_VALID = 1'b1;
        #1;
        n_checks++;
        if (PAR_calc !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: got par_calc=%b busy=%b expected 1 0",
                     tag, PAR_calc, Busy);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s bit %0d: got %b expected %b",
                         tag, i, TX_OUT, exp_q[i]);
            end
            n_checks++;
            if (Busy !== 1'b1 || PAR_calc !== 1'b0) begin
                n_fail++;
                $display("FAIL %s flags %0d: got busy=%b par_calc=%b expected 1 0",
                         tag, i, Busy, PAR_calc);
            end
            if (i == 0) begin
                DATA_VALID = 1'b0;
                P_DATA = 8'($urandom);
                PAR_EN = 1'($urandom);
            end
        end
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: got tx=%b busy=%b expected tx=1 busy=0",
                     tag, TX_OUT, Busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        add_frame(8'hA5, 1'b1, 1'b0);
        add_frame(8'h3C, 1'b0, 1'b0);
        @(negedge CLK);
        P_DATA = 8'hA5;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        #1;
        n_checks++;
        if (PAR_calc !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b first_par_calc: got %b expected 1", PAR_calc);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b bit %0d: got %b expected %b",
                         i, TX_OUT, exp_q[i]);
            end
            n_checks++;
            if (Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b busy %0d: got %b expected 1", i, Busy);
            end
            n_checks++;
            if (PAR_calc !== (i == 10)) begin
                n_fail++;
                $display("FAIL b2b par_calc %0d: got %b expected %b",
                         i, PAR_calc, (i == 10));
            end
            if (i == 0) begin
                P_DATA = 8'h3C;
                PAR_EN = 1'b0;
            end
            if (i == 11) DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b idle: got tx=%b busy=%b expected tx=1 busy=0",
                     TX_OUT, Busy);
        end
    endtask

    task automatic test_ignore_mid_frame();
        exp_q.delete();
        add_frame(8'hA5, 1'b1, 1'b0);
        @(negedge CLK);
        P_DATA = 8'hA5;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ignore bit %0d: got %b expected %b",
                         i, TX_OUT, exp_q[i]);
            end
            n_checks++;
            if (PAR_calc !== 1'b0 || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore flags %0d: got par_calc=%b busy=%b expected 0 1",
                         i, PAR_calc, Busy);
            end
            if (i == 0) DATA_VALID = 1'b0;
            if (i == 3) begin
                DATA_VALID = 1'b1;
                P_DATA = 8'hFF;
            end
            if (i == 4) DATA_VALID = 1'b0;
        end
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore idle: got tx=%b busy=%b expected tx=1 busy=0",
                     TX_OUT, Busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_q.delete();
        add_frame(8'hA5, 1'b1, 1'b0);
        @(negedge CLK);
        P_DATA = 8'hA5;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_mid bit %0d: got %b expected %b",
                         i, TX_OUT, exp_q[i]);
            end
            if (i == 0) DATA_VALID = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0 || PAR_calc !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid abort: got tx=%b busy=%b par_calc=%b expected 1 0 0",
                     TX_OUT, Busy, PAR_calc);
        end
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            n_checks++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid no_resume: got tx=%b busy=%b expected 1 0",
                         TX_OUT, Busy);
            end
        end
        test_frame(8'h96, 1'b1, 1'b0, "after_rst");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        RST = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA = 8'h00;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        test_reset();
        test_frame(8'hA5, 1'b1, 1'b0, "a5_even");
        test_frame(8'h3C, 1'b0, 1'b0, "3c_nopar");
        test_frame(8'h01, 1'b1, 1'b1, "01_odd");
        test_back_to_back();
        test_ignore_mid_frame();
        test_reset_mid_frame();
        for (int r = 0; r < 16; r++) begin
            test_frame(8'($urandom), 1'($urandom), 1'($urandom), "random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
